// File: rtl/regfile_pkg.sv
// Shared types and helpers for the clearable register file.
// Optional write-first read bypass is selected with REGFILE_BYPASS_EN.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  function automatic int rf_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // A single-entry file still needs a one-bit select.
  function automatic int rf_sel_width(input int depth);
    return (rf_clog2(depth) < 1) ? 1 : rf_clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: range check, clear masking and optional write bypass.
// REGFILE_BYPASS_EN selects write-first behaviour; otherwise the port is read-first.
module regfile_rdport #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             active,
  input  logic [AW-1:0]    sel,
  input  logic [WIDTH-1:0] mem [DEPTH],
  input  logic             byp_en,
  input  logic [AW-1:0]    byp_sel,
  input  logic [WIDTH-1:0] byp_data,
  output logic [WIDTH-1:0] data
);

  logic in_range;

  if (DEPTH == (1 << AW)) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
    assign in_range = ({1'b0, sel} < DEPTH_V);
  end

  always_comb begin
    data = '0;
    if (active && in_range) begin
`ifdef REGFILE_BYPASS_EN
      if (byp_en && (byp_sel == sel)) begin
        data = byp_data;
      end else begin
        data = mem[sel];
      end
`else
      data = mem[sel];
`endif
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_byp;
  assign unused_byp = ^{byp_en, byp_sel, byp_data};
`endif

endmodule

// File: rtl/regfile_clr.sv
// Register file that self-clears by a one-entry-per-cycle sweep after reset or on request.
// REGFILE_BYPASS_EN (see regfile_rdport) makes reads of the entry being written return new data.
module regfile_clr
  import regfile_pkg::*;
#(
  parameter  int WIDTH = 6,
  parameter  int DEPTH = 8,
  parameter  int NRD   = 2,
  localparam int AW    = rf_sel_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_req,
  input  logic [NRD*AW-1:0]  rd_sel,
  output logic [NRD*WIDTH-1:0] rd_data,
  input  logic [AW-1:0]      rw_sel,
  input  logic [WIDTH-1:0]   wd,
  input  logic               we,
  output logic               ready,
  output logic               wr_drop
);

  // cnt carries one spare bit so DEPTH=256 has an unambiguous last index.
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

  rf_state_e        state, state_nxt;
  logic [AW:0]      cnt, cnt_nxt;
  logic             wr_in_range;
  logic             wr_accept;
  logic             drop_now;
  logic             sweep;
  logic [WIDTH-1:0] mem [DEPTH];

  if (DEPTH == (1 << AW)) begin : g_wr_full
    assign wr_in_range = 1'b1;
  end else begin : g_wr_part
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
    assign wr_in_range = ({1'b0, rw_sel} < DEPTH_V);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RF_CLEAR;
      cnt     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wr_drop <= drop_now;
    end
  end

  // Clear requests arriving mid-sweep are ignored so the sweep always completes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RF_CLEAR: begin
        if (cnt == CNT_LAST) begin
          state_nxt = RF_READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      RF_READY: begin
        if (clr_req) begin
          state_nxt = RF_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RF_CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    ready     = (state == RF_READY);
    sweep     = (state == RF_CLEAR);
    wr_accept = ready && !clr_req && we && wr_in_range;
    drop_now  = we && !wr_accept;
  end

  // Storage has no reset; the sweep is the only thing that zeroes it.
  always_ff @(posedge clk) begin
    if (sweep) begin
      mem[cnt[AW-1:0]] <= '0;
    end else if (wr_accept) begin
      mem[rw_sel] <= wd;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rdport #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_rdport (
      .active   (ready),
      .sel      (rd_sel[k*AW +: AW]),
      .mem      (mem),
      .byp_en   (wr_accept),
      .byp_sel  (rw_sel),
      .byp_data (wd),
      .data     (rd_data[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: doc/regfile_clr.md
REGFILE_CLR -- requirements
Module: regfile_clr

Interface
REQ-001 SHALL have parameter WIDTH, default 6: bits per register.
REQ-002 SHALL have parameter DEPTH, default 8: register count, 2..256, not necessarily a power of two.
REQ-003 SHALL have parameter NRD, default 2: read port count, 1..4.
REQ-004 SHALL have derived localparam AW = max(1, clog2(DEPTH)): select width.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port clr_req, input, 1: request a full clear sweep.
REQ-008 SHALL have port rd_sel, input, NRD*AW: read selects; port k uses bits [k*AW +: AW].
REQ-009 SHALL have port rd_data, output, NRD*WIDTH: read data; port k on bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port rw_sel, input, AW: write select.
REQ-011 SHALL have port wd, input, WIDTH: write data.
REQ-012 SHALL have port we, input, 1: write enable.
REQ-013 SHALL have port ready, output, 1: high when the file is cleared and accepts writes.
REQ-014 SHALL have port wr_drop, output, 1: registered one-cycle pulse flagging a rejected write.

Function
REQ-015 SHALL implement a two-state controller, CLEAR and READY.
REQ-016 In CLEAR, SHALL zero entry cnt on each edge, then increment cnt; the edge that zeroes entry DEPTH-1 SHALL move to READY and set ready=1.
REQ-017 In READY, clr_req=1 at an edge SHALL move to CLEAR with cnt=0 and ready=0 from the next cycle.
REQ-018 clr_req during CLEAR SHALL be ignored; the sweep SHALL NOT restart.
REQ-019 In READY with clr_req=0, we=1 and rw_sel<DEPTH SHALL write wd to entry rw_sel on that edge.
REQ-020 A write SHALL be dropped, with wr_drop=1 the following cycle, when we=1 and any of these holds: state CLEAR; clr_req=1 in the same cycle; rw_sel>=DEPTH.
REQ-021 Reads SHALL be combinational, with zero latency.
REQ-022 rd_data for port k SHALL be 0 while in CLEAR or when its select is >=DEPTH; otherwise it SHALL be entry rd_sel[k].
REQ-023 Multiple read ports selecting the same entry SHALL all return the same value.
REQ-024 cnt SHALL be AW+1 bits wide so that DEPTH=256 terminates without wrap ambiguity.

Reset
REQ-025 rst_n low SHALL immediately force state=CLEAR, cnt=0, ready=0, wr_drop=0.
REQ-026 Storage SHALL NOT be asynchronously reset; it is zeroed only by the sweep.
REQ-027 After rst_n deassertion, ready SHALL rise after exactly DEPTH rising edges.
REQ-028 Reset asserted mid-sweep or mid-write SHALL abort the operation, and the sweep SHALL restart from entry 0.

Configuration
REQ-029 The macro REGFILE_BYPASS_EN SHALL control same-cycle read-during-write behaviour.
REQ-030 When REGFILE_BYPASS_EN is defined: in READY, a read port whose select equals rw_sel during an accepted write SHALL return wd in that cycle (write-first).
REQ-031 When REGFILE_BYPASS_EN is undefined: a read port in that situation SHALL return the old stored value (read-first).
REQ-032 A dropped write SHALL never bypass, in either configuration.

Structure
REQ-033 Package regfile_pkg SHALL hold the state typedef (RF_CLEAR, RF_READY) and the clog2 helper function.
REQ-034 Sub-module regfile_rdport (one select-to-data mux including the range check and bypass) SHALL be instantiated NRD times via generate.

Verification (WIDTH=6, DEPTH=8, NRD=2)
REQ-035 Release rst_n -> ready=0 for 8 edges, then 1; every rd_sel returns 0.
REQ-036 With ready=1, write 6'h2A to entry 5, then read rd_sel={5,5} -> both ports return 6'h2A the next cycle.
REQ-037 Write 6'h15 to entry 3 while port0 reads 3 -> port0 returns 6'h15 in the same cycle with REGFILE_BYPASS_EN defined, and the old value without it.
REQ-038 clr_req and we=1 (entry 2, 6'h3F) in the same cycle -> wr_drop pulses once, ready=0 for 8 cycles, and entry 2 reads 0 afterwards.
REQ-039 Write during CLEAR, and write to rw_sel=7 with DEPTH=7 -> wr_drop=1 each time and no entry changes.
REQ-040 Assert rst_n mid-sweep at cnt=4 -> ready stays 0, and a full 8-edge sweep follows deassertion.
